// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch front end: credit-limited imem requests, PC-tagged FIFO toward decode,
// redirect flush with stale-response discard. Define FETCH_PERF_EN to add perf_* counter outputs.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [ILEN-1:0] data_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];

  logic credit_ok;
  logic accept;
  logic rsp_fire;
  logic rsp_drop;
  logic push;
  logic pop;
  logic [XLEN-1:0] redirect_aligned;

  // Credits cover both in-flight requests and buffered entries, so a response always has a slot.
  assign credit_ok        = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
  assign imem_req_valid   = reset && !redirect_valid && credit_ok;
  assign imem_req_addr    = fetch_pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign rsp_fire         = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop         = rsp_fire && (redirect_valid || (drop_cnt != '0));
  assign push             = rsp_fire && !rsp_drop;
  assign inst_valid       = (count != '0) && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign inst_data        = data_mem[rd_ptr];
  assign inst_pc          = pc_mem[rd_ptr];
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_fire);
      if (redirect_valid) begin
        // Every request still in flight (including already-stale ones) becomes a drop.
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        drop_cnt <= outstanding - CW'(rsp_fire);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          data_mem[wr_ptr] <= imem_rsp_data;
          pc_mem[wr_ptr]   <= resp_pc;
          wr_ptr           <= wr_ptr + PW'(1);
          resp_pc          <= resp_pc + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (rsp_drop) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
      if (!imem_req_valid && !redirect_valid) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// scoreboard of expected PCs checked on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // In-order instruction memory with fixed latency in cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];
  int cyc = 0;
  int lat = 1;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      acc_cnt++;
    end
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= mem_f(mq[0].addr);
    end else begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end
  end

  // Scoreboard: expected PCs are queued by the stimulus, consumed on each handshake.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (reset && inst_valid && inst_ready) begin
      chk("handshake_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst_data", inst_data, mem_f(e));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    repeat (10) next_cycle();
    exp_q.delete();
    acc_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; inst_ready = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
`endif

    // Streaming: 1-cycle memory, decode always ready
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t1_inst_valid", 32'(inst_valid), 32'(c >= 2));
      next_cycle();
    end
    chk("t1_consumed", 32'(exp_q.size()), 32'd12);
`ifdef FETCH_PERF_EN
    chk("t1_perf_fetched", perf_fetched, 32'd8);
`endif

    // Decode stalled: credit limit then drain
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b1;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("t2_accepted", 32'(acc_cnt), 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_head_pc", inst_pc, 32'h0);
    next_cycle();
    inst_ready = 1'b1;
    repeat (6) next_cycle();
    chk("t2_drained", 32'(exp_q.size()), 32'd2);

    // Redirect with two stale responses in flight, 3-cycle memory
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    chk("t3_redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    @(negedge clk);
    chk("t3_empty_after", 32'(inst_valid), 32'd0);
    chk("t3_req_addr", imem_req_addr, 32'h100);
    repeat (6) next_cycle();
    inst_ready = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("t3_consumed", 32'(exp_q.size()), 32'd0);
    chk("t3_head_pc", inst_pc, 32'h108);

    // Redirect coinciding with a response and a ready decode
    do_reset();
    lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b1;
    reset = 1'b1;
    repeat (3) next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    repeat (5) next_cycle();
    inst_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("t4_consumed", 32'(exp_q.size()), 32'd0);
    chk("t4_head_pc", inst_pc, 32'h208);
`ifdef FETCH_PERF_EN
    chk("t4_perf_fetched", perf_fetched, 32'd2);
    chk("t4_perf_dropped", perf_dropped, 32'd2);
`endif

    // Redirect near the top of the address space, unaligned target
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    next_cycle();
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk);
    chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (5) next_cycle();
    inst_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("t5_consumed", 32'(exp_q.size()), 32'd0);
    chk("t5_head_pc", inst_pc, 32'h8);

    // Reset mid-stream with two responses still owed by memory
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b0; reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetched", perf_fetched, 32'd0);
    chk("t6_perf_dropped", perf_dropped, 32'd0);
    chk("t6_perf_stall", perf_stall, 32'd0);
`endif
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (6) next_cycle();
    inst_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("t6_consumed", 32'(exp_q.size()), 32'd0);
    chk("t6_head_pc", inst_pc, 32'h8);
    chk("t6_head_data", inst_data, mem_f(32'h8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
